// File: rtl/sdram_arb_pkg.sv
// Shared widths and types for the SDRAM local-port arbiter.
// Field widths, requester id, slot state and command op.
package sdram_arb_pkg;

  localparam int ARB_DATA_W    = 64;
  localparam int ARB_CS_W      = 1;
  localparam int ARB_ROW_W     = 13;
  localparam int ARB_BANK_W    = 2;
  localparam int ARB_COL_W     = 8;
  localparam int ARB_TAG_DEPTH = 8;

  typedef logic req_id_t;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } slot_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order read tag FIFO: remembers which requester owns each read.
// Ports: i_push/i_push_id in, i_pop in, o_pop_id/o_count/o_full/o_empty out.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = ARB_TAG_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  req_id_t                  i_push_id,
  input  logic                     i_pop,
  output req_id_t                  o_pop_id,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  req_id_t        r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  // A pop on an empty FIFO is ignored here; the caller flags it.
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && !o_full;

  assign o_count  = r_count;
  assign o_full   = (r_count == (PW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_pop_id = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_local_port_arbiter.sv
// Round-robin two-requester front end for the DDR controller local port.
// Ports: r0_*/r1_* requester sides, local_* controller side, err_orphan_rdata flag.
module sdram_local_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int DATA_W    = ARB_DATA_W,
  parameter int CS_W      = ARB_CS_W,
  parameter int ROW_W     = ARB_ROW_W,
  parameter int BANK_W    = ARB_BANK_W,
  parameter int COL_W     = ARB_COL_W,
  parameter int ADDR_W    = CS_W + ROW_W + BANK_W + COL_W,
  parameter int TAG_DEPTH = ARB_TAG_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_be,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic                r0_rdata_valid,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_be,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                r1_rdata_valid,
  input  logic                local_init_done,
  input  logic                local_ready,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic                local_read_req,
  output logic                local_write_req,
  output logic [CS_W-1:0]     local_cs_addr,
  output logic [ROW_W-1:0]    local_row_addr,
  output logic [BANK_W-1:0]   local_bank_addr,
  output logic [COL_W-1:0]    local_col_addr,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  output logic                local_size,
  output logic                local_burstbegin,
  output logic                err_orphan_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(TAG_DEPTH);

  slot_state_t       r_state;
  op_t               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_first;
  req_id_t           r_last_grant;
  logic              r_rv;
  req_id_t           r_rv_id;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_free;
  logic              w_tag_ok;
  logic              w_el0;
  logic              w_el1;
  logic              w_load;
  req_id_t           w_grant;
  logic              w_sel_rd;
  op_t               w_op;
  logic              w_push;
  logic              w_pop_ok;
  logic              w_orphan;
  req_id_t           w_pop_id;
  logic [CW:0]       w_count;
  logic              w_full;
  logic              w_empty;

  // Slot can take a new command if empty or if it drains this cycle.
  assign w_free   = (r_state == EMPTY) || local_ready;
  assign w_tag_ok = !w_full;

  // Read has priority within a requester; a tag-starved read stalls it.
  assign w_el0 = reset_n && local_init_done && w_free &&
                 (r0_read ? w_tag_ok : r0_write);
  assign w_el1 = reset_n && local_init_done && w_free &&
                 (r1_read ? w_tag_ok : r1_write);
  assign w_load = w_el0 || w_el1;

  always_comb begin
    w_grant = r_last_grant;
    unique case (1'b1)
      w_el0 && !w_el1: w_grant = 1'b0;
      !w_el0 && w_el1: w_grant = 1'b1;
      w_el0 && w_el1:  w_grant = ~r_last_grant;
      default:         w_grant = r_last_grant;
    endcase
  end

  assign w_sel_rd = w_grant ? r1_read : r0_read;
  assign w_op     = w_sel_rd ? RD : WR;
  assign w_push   = w_load && (w_op == RD);
  assign w_pop_ok = local_rdata_valid && !w_empty;
  assign w_orphan = local_rdata_valid && (w_count == '0);

  assign r0_waitrequest = !(w_load && (w_grant == 1'b0));
  assign r1_waitrequest = !(w_load && (w_grant == 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_op         <= RD;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_first      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_first <= w_load;
      if (w_load) begin
        r_state      <= PENDING;
        r_op         <= w_op;
        r_addr       <= w_grant ? r1_addr : r0_addr;
        r_wdata      <= w_grant ? r1_wdata : r0_wdata;
        r_be         <= w_grant ? r1_be : r0_be;
        r_last_grant <= w_grant;
      end else if (local_ready) begin
        r_state <= EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rv    <= 1'b0;
      r_rv_id <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rv <= w_pop_ok;
      if (w_pop_ok) begin
        r_rv_id <= w_pop_id;
        r_rdata <= local_rdata;
      end
      if (w_orphan) r_err <= 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_push    (w_push),
    .i_push_id (w_grant),
    .i_pop     (local_rdata_valid),
    .o_pop_id  (w_pop_id),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign local_read_req   = (r_state == PENDING) && (r_op == RD);
  assign local_write_req  = (r_state == PENDING) && (r_op == WR);
  assign local_cs_addr    = r_addr[ADDR_W-1 -: CS_W];
  assign local_row_addr   = r_addr[COL_W+BANK_W +: ROW_W];
  assign local_bank_addr  = r_addr[COL_W +: BANK_W];
  assign local_col_addr   = r_addr[0 +: COL_W];
  assign local_wdata      = r_wdata;
  assign local_be         = r_be;
  assign local_size       = 1'b1;
  assign local_burstbegin = r_first;
  assign err_orphan_rdata = r_err;

  assign r0_rdata       = r_rdata;
  assign r1_rdata       = r_rdata;
  assign r0_rdata_valid = r_rv && (r_rv_id == 1'b0);
  assign r1_rdata_valid = r_rv && (r_rv_id == 1'b1);

endmodule

// File: tb/tb_sdram_local_port_arbiter.sv
// Bench for sdram_local_port_arbiter: vector table, corner sequences,
// and random traffic against a queue-based transaction model.
module tb_sdram_local_port_arbiter;

  localparam int DW = 64;
  localparam int BW = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [BW-1:0] r0_be, r1_be;
  logic          r0_waitrequest, r1_waitrequest;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          r0_rdata_valid, r1_rdata_valid;
  logic          local_init_done, local_ready;
  logic [DW-1:0] local_rdata;
  logic          local_rdata_valid;
  logic          local_read_req, local_write_req;
  logic [0:0]    local_cs_addr;
  logic [12:0]   local_row_addr;
  logic [1:0]    local_bank_addr;
  logic [7:0]    local_col_addr;
  logic [DW-1:0] local_wdata;
  logic [BW-1:0] local_be;
  logic          local_size, local_burstbegin, err_orphan_rdata;

  sdram_local_port_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .r0_read           (r0_read),
    .r0_write          (r0_write),
    .r0_addr           (r0_addr),
    .r0_wdata          (r0_wdata),
    .r0_be             (r0_be),
    .r0_waitrequest    (r0_waitrequest),
    .r0_rdata          (r0_rdata),
    .r0_rdata_valid    (r0_rdata_valid),
    .r1_read           (r1_read),
    .r1_write          (r1_write),
    .r1_addr           (r1_addr),
    .r1_wdata          (r1_wdata),
    .r1_be             (r1_be),
    .r1_waitrequest    (r1_waitrequest),
    .r1_rdata          (r1_rdata),
    .r1_rdata_valid    (r1_rdata_valid),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .local_read_req    (local_read_req),
    .local_write_req   (local_write_req),
    .local_cs_addr     (local_cs_addr),
    .local_row_addr    (local_row_addr),
    .local_bank_addr   (local_bank_addr),
    .local_col_addr    (local_col_addr),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_size        (local_size),
    .local_burstbegin  (local_burstbegin),
    .err_orphan_rdata  (err_orphan_rdata)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk64(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk64(name, 64'(act), 64'(exp));
  endtask

  // Transaction-level model: one command slot, a queue of read owners.
  bit            m_pend, m_first, m_lg, m_rv, m_rvid, m_err, m_isrd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;
  logic [BW-1:0] m_be;
  int            q[$];
  bit            p_load, p_gnt;

  task automatic model_reset();
    m_pend = 0; m_first = 0; m_lg = 1; m_rv = 0; m_rvid = 0;
    m_err = 0; m_isrd = 0; m_addr = '0; m_wd = '0; m_rd = '0;
    m_be = '0; q.delete();
  endtask

  task automatic model_check();
    bit free, el0, el1;
    free = !m_pend || local_ready;
    el0 = local_init_done && free && (r0_read ? (q.size() < 8) : r0_write);
    el1 = local_init_done && free && (r1_read ? (q.size() < 8) : r1_write);
    p_load = el0 || el1;
    p_gnt  = (el0 && el1) ? !m_lg : el1;
    chk1("m r0_waitrequest", r0_waitrequest, !(p_load && !p_gnt));
    chk1("m r1_waitrequest", r1_waitrequest, !(p_load && p_gnt));
    chk1("m read_req", local_read_req, m_pend && m_isrd);
    chk1("m write_req", local_write_req, m_pend && !m_isrd);
    chk1("m burstbegin", local_burstbegin, m_pend && m_first);
    chk64("m cs", 64'(local_cs_addr), 64'(m_addr >> 23));
    chk64("m row", 64'(local_row_addr), 64'((m_addr >> 10) & 24'h1fff));
    chk64("m bank", 64'(local_bank_addr), 64'((m_addr >> 8) & 24'h3));
    chk64("m col", 64'(local_col_addr), 64'(m_addr & 24'hff));
    chk64("m wdata", local_wdata, m_wd);
    chk64("m be", 64'(local_be), 64'(m_be));
    chk1("m size", local_size, 1'b1);
    chk1("m r0_rdata_valid", r0_rdata_valid, m_rv && !m_rvid);
    chk1("m r1_rdata_valid", r1_rdata_valid, m_rv && m_rvid);
    chk64("m r0_rdata", r0_rdata, m_rd);
    chk64("m r1_rdata", r1_rdata, m_rd);
    chk1("m err", err_orphan_rdata, m_err);
  endtask

  task automatic model_update();
    if (local_rdata_valid) begin
      if (q.size() == 0) begin
        m_err = 1; m_rv = 0;
      end else begin
        m_rv = 1; m_rvid = q.pop_front() != 0; m_rd = local_rdata;
      end
    end else begin
      m_rv = 0;
    end
    if (p_load) begin
      m_isrd = p_gnt ? r1_read : r0_read;
      m_addr = p_gnt ? r1_addr : r0_addr;
      m_wd   = p_gnt ? r1_wdata : r0_wdata;
      m_be   = p_gnt ? r1_be : r0_be;
      if (m_isrd) q.push_back(int'(p_gnt));
      m_pend = 1; m_first = 1; m_lg = p_gnt;
    end else begin
      m_first = 0;
      if (local_ready) m_pend = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
    local_ready = 1; local_init_done = 1; local_rdata_valid = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    chk1("rst r0_waitrequest", r0_waitrequest, 1'b1);
    chk1("rst r1_waitrequest", r1_waitrequest, 1'b1);
    chk1("rst r0_rdata_valid", r0_rdata_valid, 1'b0);
    chk1("rst r1_rdata_valid", r1_rdata_valid, 1'b0);
    chk64("rst r0_rdata", r0_rdata, 64'h0);
    chk1("rst read_req", local_read_req, 1'b0);
    chk1("rst write_req", local_write_req, 1'b0);
    chk1("rst burstbegin", local_burstbegin, 1'b0);
    chk64("rst addr", 64'({local_cs_addr, local_row_addr,
                          local_bank_addr, local_col_addr}), 64'h0);
    chk64("rst wdata", local_wdata, 64'h0);
    chk64("rst be", 64'(local_be), 64'h0);
    chk1("rst size", local_size, 1'b1);
    chk1("rst err", err_orphan_rdata, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  typedef struct {
    bit          w0, w1;
    bit          e_wait0, e_wait1, e_wreq;
    logic [63:0] e_wd;
  } vec_t;

  localparam logic [63:0] WD0 = 64'hA0A0_0000_0000_00A0;
  localparam logic [63:0] WD1 = 64'hB1B1_0000_0000_00B1;

  vec_t        tv[6];
  logic [63:0] rd_d[3];
  bit          rd_id[3];

  initial begin
    reset_n = 0;
    idle();
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    r0_be = '0; r1_be = '0; local_rdata = '0;

    tv[0] = '{1, 1, 0, 1, 0, 64'h0};
    tv[1] = '{1, 1, 1, 0, 1, WD0};
    tv[2] = '{1, 1, 0, 1, 1, WD1};
    tv[3] = '{1, 1, 1, 0, 1, WD0};
    tv[4] = '{0, 0, 1, 1, 1, WD1};
    tv[5] = '{0, 0, 1, 1, 0, 64'h0};

    do_reset();

    // init_done low blocks loads; raising it lets the read through.
    local_init_done = 0;
    r0_read = 1; r0_addr = 24'h00_0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("init0 r0_waitrequest", r0_waitrequest, 1'b1);
      chk1("init0 read_req", local_read_req, 1'b0);
      cyc();
    end
    local_init_done = 1;
    #1;
    chk1("init1 r0_waitrequest", r0_waitrequest, 1'b0);
    cyc();
    r0_read = 0;
    chk1("init1 read_req", local_read_req, 1'b1);

    // Round-robin writes, table driven.
    do_reset();
    idle();
    r0_wdata = WD0; r1_wdata = WD1; r0_be = 8'hFF; r1_be = 8'h0F;
    for (int i = 0; i < 6; i++) begin
      r0_write = tv[i].w0; r1_write = tv[i].w1;
      #1;
      chk1("rr r0_waitrequest", r0_waitrequest, tv[i].e_wait0);
      chk1("rr r1_waitrequest", r1_waitrequest, tv[i].e_wait1);
      chk1("rr write_req", local_write_req, tv[i].e_wreq);
      if (tv[i].e_wreq) chk64("rr wdata", local_wdata, tv[i].e_wd);
      cyc();
    end

    // Address decode with controller stalling three cycles.
    do_reset();
    idle();
    local_ready = 0;
    r0_read = 1; r0_addr = 24'h81_2345;
    #1;
    chk1("addr r0_waitrequest", r0_waitrequest, 1'b0);
    cyc();
    r0_read = 0;
    for (int i = 0; i < 4; i++) begin
      local_ready = (i == 3);
      #1;
      chk1("addr read_req", local_read_req, 1'b1);
      chk1("addr burstbegin", local_burstbegin, i == 0);
      chk64("addr cs", 64'(local_cs_addr), 64'h1);
      chk64("addr row", 64'(local_row_addr), 64'h48);
      chk64("addr bank", 64'(local_bank_addr), 64'h3);
      chk64("addr col", 64'(local_col_addr), 64'h45);
      cyc();
    end
    #1;
    chk1("addr read_req done", local_read_req, 1'b0);

    // Tag FIFO full: ninth read stalls, a write from r0 still passes.
    do_reset();
    idle();
    r1_read = 1;
    for (int i = 0; i < 8; i++) begin
      r1_addr = 24'(i);
      #1;
      chk1("full r1 accept", r1_waitrequest, 1'b0);
      cyc();
    end
    r1_addr = 24'h9; r0_write = 1; r0_wdata = 64'h55;
    #1;
    chk1("full r1 stall", r1_waitrequest, 1'b1);
    chk1("full r0 write", r0_waitrequest, 1'b0);
    cyc();
    r0_write = 0;
    #1;
    chk1("full r1 stall2", r1_waitrequest, 1'b1);
    cyc();
    local_rdata_valid = 1; local_rdata = 64'h77;
    #1;
    chk1("full r1 stall3", r1_waitrequest, 1'b1);
    cyc();
    local_rdata_valid = 0;
    #1;
    chk1("full r1 after pop", r1_waitrequest, 1'b0);
    chk1("full r1_rdata_valid", r1_rdata_valid, 1'b1);
    chk64("full r1_rdata", r1_rdata, 64'h77);
    cyc();
    r1_read = 0;

    // Interleaved reads come back to their owners in order.
    do_reset();
    idle();
    rd_d[0] = 64'hA; rd_d[1] = 64'hB; rd_d[2] = 64'hC;
    rd_id[0] = 0; rd_id[1] = 1; rd_id[2] = 0;
    for (int i = 0; i < 3; i++) begin
      r0_read = !rd_id[i]; r1_read = rd_id[i];
      cyc();
    end
    r0_read = 0; r1_read = 0;
    for (int i = 0; i < 3; i++) begin
      local_rdata_valid = 1; local_rdata = rd_d[i];
      #1;
      chk1("rd no early valid", r0_rdata_valid | r1_rdata_valid, i != 0);
      cyc();
      chk1("rd r0_rdata_valid", r0_rdata_valid, !rd_id[i]);
      chk1("rd r1_rdata_valid", r1_rdata_valid, rd_id[i]);
      chk64("rd data", rd_id[i] ? r1_rdata : r0_rdata, rd_d[i]);
    end
    local_rdata_valid = 0;
    cyc();
    chk1("rd valid cleared", r0_rdata_valid | r1_rdata_valid, 1'b0);

    // Orphan beat sets a sticky error.
    do_reset();
    idle();
    #1;
    chk1("orphan err before", err_orphan_rdata, 1'b0);
    local_rdata_valid = 1; local_rdata = 64'hDEAD;
    cyc();
    local_rdata_valid = 0;
    chk1("orphan err set", err_orphan_rdata, 1'b1);
    chk1("orphan no valid", r0_rdata_valid | r1_rdata_valid, 1'b0);
    repeat (3) cyc();
    chk1("orphan err sticky", err_orphan_rdata, 1'b1);

    // Reset in the middle of write traffic.
    r0_write = 1; r1_write = 1;
    repeat (3) cyc();
    do_reset();
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      local_init_done = ($urandom_range(0, 15) != 0);
      local_ready = ($urandom_range(0, 3) != 0);
      r0_read  = ($urandom_range(0, 2) == 0);
      r0_write = ($urandom_range(0, 2) == 0);
      r1_read  = ($urandom_range(0, 2) == 0);
      r1_write = ($urandom_range(0, 2) == 0);
      r0_addr  = 24'($urandom);
      r1_addr  = 24'($urandom);
      r0_wdata = {$urandom, $urandom};
      r1_wdata = {$urandom, $urandom};
      r0_be    = 8'($urandom);
      r1_be    = 8'($urandom);
      local_rdata_valid = ($urandom_range(0, 3) == 0);
      local_rdata = {$urandom, $urandom};
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
